// File: rtl/alu_1.sv
// rtl/alu_1.sv - registered 3-bit add/sub/mul/logic unit with one-cycle valid
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   X, Y       3-bit unsigned operands
//   OP         00 add, 01 subtract (mod 64), 10 multiply, 11 {X&Y, X|Y}
//   in_valid   operands/opcode sampled on a rising edge when high
//   Z          6-bit registered result, held while in_valid is low
//   out_valid  registered copy of in_valid

module alu_1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] X,
    input  logic [2:0] Y,
    input  logic [1:0] OP,
    input  logic       in_valid,
    output logic [5:0] Z,
    output logic       out_valid
);

    logic [5:0] x_ext;
    logic [5:0] y_ext;
    logic [5:0] z_next;

    assign x_ext = {3'b000, X};
    assign y_ext = {3'b000, Y};

    // All arithmetic is done at the full 6-bit result width so that
    // subtraction wraps modulo 64 and the 7*7 product fits without truncation.
    always_comb begin
        z_next = 6'd0;
        case (OP)
            2'b00:   z_next = x_ext + y_ext;
            2'b01:   z_next = x_ext - y_ext;
            2'b10:   z_next = x_ext * y_ext;
            default: z_next = {X & Y, X | Y};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Z         <= 6'd0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Z <= z_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_1.sv
// tb/tb_alu_1.sv - directed and randomised self-checking bench for alu_1

module tb_alu_1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] X = 3'd0;
    logic [2:0] Y = 3'd0;
    logic [1:0] OP = 2'd0;
    logic       in_valid = 1'b0;
    logic [5:0] Z;
    logic       out_valid;

    int total = 0;
    int bad = 0;

    alu_1 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .OP        (OP),
        .in_valid  (in_valid),
        .Z         (Z),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample just after the next rising edge.
    task automatic step(input logic [2:0] x, input logic [2:0] y, input logic [1:0] op,
                        input logic v);
        @(negedge clk);
        X = x;
        Y = y;
        OP = op;
        in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] ez, input logic ev);
        chk({tag, ".z"}, Z, ez);
        chk({tag, ".v"}, {5'd0, out_valid}, {5'd0, ev});
    endtask

    function automatic logic [5:0] model(input int x, input int y, input int op);
        int r;
        case (op)
            0:       r = x + y;
            1:       r = (x - y + 64) % 64;
            2:       r = x * y;
            default: r = ((x & y) * 8) + (x | y);
        endcase
        return r[5:0];
    endfunction

    initial begin
        logic [5:0] ez;
        logic       ev;

        // Reset held from time zero.
        @(posedge clk);
        #1;
        expect_out("reset_init", 6'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // X=3, Y=4 across all opcodes.
        step(3'd3, 3'd4, 2'b00, 1'b1); expect_out("add_3_4", 6'd7, 1'b1);
        step(3'd3, 3'd4, 2'b01, 1'b1); expect_out("sub_3_4", 6'd63, 1'b1);
        step(3'd3, 3'd4, 2'b10, 1'b1); expect_out("mul_3_4", 6'd12, 1'b1);
        step(3'd3, 3'd4, 2'b11, 1'b1); expect_out("log_3_4", 6'b000111, 1'b1);

        // Boundaries.
        step(3'd7, 3'd7, 2'b00, 1'b1); expect_out("add_7_7", 6'd14, 1'b1);
        step(3'd7, 3'd7, 2'b10, 1'b1); expect_out("mul_7_7", 6'd49, 1'b1);
        step(3'd7, 3'd7, 2'b11, 1'b1); expect_out("log_7_7", 6'b111111, 1'b1);
        step(3'd0, 3'd7, 2'b01, 1'b1); expect_out("sub_0_7", 6'd57, 1'b1);
        step(3'd5, 3'd2, 2'b11, 1'b1); expect_out("log_5_2", 6'b000111, 1'b1);
        step(3'd6, 3'd3, 2'b11, 1'b1); expect_out("log_6_3", 6'b010111, 1'b1);

        // Idle cycle, then back-to-back.
        step(3'd1, 3'd1, 2'b00, 1'b0); expect_out("idle", 6'b010111, 1'b0);
        step(3'd3, 3'd4, 2'b00, 1'b1); expect_out("b2b_0", 6'd7, 1'b1);
        step(3'd3, 3'd4, 2'b01, 1'b1); expect_out("b2b_1", 6'd63, 1'b1);
        step(3'd3, 3'd4, 2'b10, 1'b1); expect_out("b2b_2", 6'd12, 1'b1);
        step(3'd3, 3'd4, 2'b11, 1'b1); expect_out("b2b_3", 6'd7, 1'b1);

        // Hold: Z=12, then toggling inputs with in_valid low.
        step(3'd3, 3'd4, 2'b10, 1'b1); expect_out("hold_setup", 6'd12, 1'b1);
        step(3'd7, 3'd7, 2'b00, 1'b0); expect_out("hold_0", 6'd12, 1'b0);
        step(3'd0, 3'd5, 2'b11, 1'b0); expect_out("hold_1", 6'd12, 1'b0);
        step(3'd6, 3'd1, 2'b01, 1'b0); expect_out("hold_2", 6'd12, 1'b0);

        // Asynchronous reset mid-cycle with an operation in flight.
        step(3'd7, 3'd7, 2'b10, 1'b1); expect_out("pre_reset", 6'd49, 1'b1);
        @(negedge clk);
        X = 3'd5; Y = 3'd5; OP = 2'b00; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("reset_async", 6'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_out("reset_held", 6'd0, 1'b0);
        // Release with in_valid high: first edge samples normally.
        @(negedge clk);
        rst_n = 1'b1;
        X = 3'd7; Y = 3'd7; OP = 2'b10; in_valid = 1'b1;
        @(posedge clk);
        #1;
        expect_out("post_reset", 6'd49, 1'b1);

        // Random vectors with occasional reset pulses inside a cycle.
        ez = 6'd49;
        ev = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [2:0] rx;
            logic [2:0] ry;
            logic [1:0] rop;
            logic       rv;
            rx  = 3'($urandom_range(0, 7));
            ry  = 3'($urandom_range(0, 7));
            rop = 2'($urandom_range(0, 3));
            rv  = 1'($urandom_range(0, 1));
            @(negedge clk);
            X = rx; Y = ry; OP = rop; in_valid = rv;
            if ($urandom_range(0, 15) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                ez = 6'd0;
                ev = 1'b0;
                chk("rand_rst.z", Z, ez);
                #1;
                rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if (rv) ez = model(int'(rx), int'(ry), int'(rop));
            ev = rv;
            chk("rand.z", Z, ez);
            chk("rand.v", {5'd0, out_valid}, {5'd0, ev});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
